// File: rtl/brief_desc_packer.sv
`default_nettype none
// ============================================================================
//  Module   : brief_desc_packer
//  Purpose  : Receiving end of the BRIEF descriptor stream. Each flagged
//             keypoint is captured into a record FIFO and serialised onto a
//             32-bit valid/ready word stream. A trailer word carrying the
//             frame's keypoint and drop counts is appended per frame end.
//
//  Ports    : i_clk, i_rst         clock, synchronous active-high reset
//             i_pixel_valid        qualifies every other stream input
//             i_flag               keypoint present this cycle
//             i_coor_x/_y, i_score keypoint coordinate and score
//             i_descriptor         256-bit BRIEF descriptor
//             i_start, i_end       frame start / end pulses
//             o_data, o_valid      output word and qualifier
//             i_ready              downstream accepts the word
//             o_last               last word of the current record
//             o_overflow           sticky: a keypoint was dropped
//
//  Options  : BRIEF_PACK_CHECKSUM_EN - when defined, keypoint records carry
//             a tenth word equal to the XOR of words 0..8.
//
//  Revision : 1.0 - initial release
// ============================================================================
module brief_desc_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pixel_valid,
    input  logic         i_flag,
    input  logic [9:0]   i_coor_x,
    input  logic [9:0]   i_coor_y,
    input  logic [7:0]   i_score,
    input  logic [255:0] i_descriptor,
    input  logic         i_start,
    input  logic         i_end,
    output logic [31:0]  o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last,
    output logic         o_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    // Entry layout: [288] trailer marker, [287:256] word 0, [255:0] descriptor
    localparam int c_ENT_W = 1 + 32 + 256;
`ifdef BRIEF_PACK_CHECKSUM_EN
    localparam logic [3:0] c_KP_LAST = 4'd9;
`else
    localparam logic [3:0] c_KP_LAST = 4'd8;
`endif
    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0] c_TWO      = c_OCC_W'(2);
    localparam logic [9:0]         c_DROP_MAX = 10'h3FF;
    localparam logic [CNT_W-1:0]   c_KP_MAX   = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;
    logic [CNT_W-1:0]   r_kp_cnt;
    logic [9:0]         r_drop_cnt;
    logic               r_overflow;
    logic               r_valid;
    logic [31:0]        r_data;
    logic               r_last;
    logic [3:0]         r_widx;

    // ------------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------------
    logic               w_kp;
    logic               w_end;
    logic               w_start;
    logic [c_OCC_W-1:0] w_free;
    logic [c_OCC_W-1:0] w_free_after_tr;
    logic               w_push_tr;
    logic               w_kp_ok;
    logic               w_kp_drop;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_kp_wr_ptr;
    logic [15:0]        w_kp16;
    logic [31:0]        w_hdr;
    logic [31:0]        w_trl;
    logic               w_new_frame;
    logic [CNT_W-1:0]   w_kp_base;
    logic [9:0]         w_drop_base;
    logic [CNT_W-1:0]   w_kp_nxt;
    logic [9:0]         w_drop_nxt;

    generate
        if (CNT_W >= 16) begin : g_kp_trunc
            assign w_kp16 = r_kp_cnt[15:0];
        end else begin : g_kp_ext
            assign w_kp16 = {{(16-CNT_W){1'b0}}, r_kp_cnt};
        end
    endgenerate

    always_comb begin
        w_kp    = i_pixel_valid & i_flag;
        w_end   = i_pixel_valid & i_end;
        w_start = i_pixel_valid & i_start;
        w_pop   = r_valid & i_ready & r_last;

        // Free space is judged on occupancy before this cycle's pop.
        w_free          = c_DEPTH - r_count;
        w_push_tr       = w_end && (w_free != '0);
        w_free_after_tr = w_free - c_OCC_W'(w_push_tr);
        // The trailer goes in first; the keypoint must then still leave one
        // slot spare so the next frame end always finds room.
        w_kp_ok     = w_kp && (w_free_after_tr >= c_TWO);
        w_kp_drop   = w_kp && !w_kp_ok;
        w_kp_wr_ptr = r_wr_ptr + c_PTR_W'(w_push_tr);

        w_hdr = {2'b01, i_coor_y, i_coor_x, i_score, 2'b00};
        // Trailer reflects the closing frame; a same-cycle keypoint or drop
        // belongs to the next frame and is not included.
        w_trl = {2'b10, r_drop_cnt, 4'b0000, w_kp16};

        w_new_frame = w_end | w_start;
        w_kp_base   = w_new_frame ? '0 : r_kp_cnt;
        w_drop_base = w_new_frame ? '0 : r_drop_cnt;
        w_kp_nxt    = (w_kp_ok && (w_kp_base != c_KP_MAX))
                      ? w_kp_base + CNT_W'(1) : w_kp_base;
        w_drop_nxt  = (w_kp_drop && (w_drop_base != c_DROP_MAX))
                      ? w_drop_base + 10'd1 : w_drop_base;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_push_tr) r_mem[r_wr_ptr]    <= {1'b1, w_trl, 256'd0};
            if (w_kp_ok)   r_mem[w_kp_wr_ptr] <= {1'b0, w_hdr, i_descriptor};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_kp_cnt   <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + c_PTR_W'(w_push_tr) + c_PTR_W'(w_kp_ok);
            r_rd_ptr   <= r_rd_ptr + c_PTR_W'(w_pop);
            r_count    <= r_count + c_OCC_W'(w_push_tr) + c_OCC_W'(w_kp_ok)
                          - c_OCC_W'(w_pop);
            r_kp_cnt   <= w_kp_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (w_kp_drop) r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output side: the output register always holds a word of the entry at
    // r_rd_ptr, which stays in the FIFO until its last word is accepted.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] f_word(input logic [c_ENT_W-1:0] ent,
                                           input logic [3:0]         idx);
        logic [31:0] res;
        res = ent[287:256];
        if (idx >= 4'd1 && idx <= 4'd8) begin
            res = ent[32*(int'(idx)-1) +: 32];
        end
`ifdef BRIEF_PACK_CHECKSUM_EN
        else if (idx == 4'd9) begin
            for (int k = 0; k < 8; k++) res = res ^ ent[32*k +: 32];
        end
`endif
        return res;
    endfunction

    logic               w_advance;
    logic               w_load_new;
    logic               w_avail;
    logic [c_PTR_W-1:0] w_sel_ptr;
    logic [3:0]         w_sel_idx;
    logic [c_ENT_W-1:0] w_sel_entry;
    logic [31:0]        w_sel_word;
    logic               w_sel_last;

    always_comb begin
        w_advance   = r_valid & i_ready & ~r_last;
        // Idle, or head record just finished: start the next record at once.
        w_load_new  = ~r_valid | w_pop;
        w_avail     = (r_count - c_OCC_W'(w_pop)) != '0;
        w_sel_ptr   = w_load_new ? (r_rd_ptr + c_PTR_W'(w_pop)) : r_rd_ptr;
        w_sel_idx   = w_load_new ? 4'd0 : (r_widx + 4'd1);
        w_sel_entry = r_mem[w_sel_ptr];
        w_sel_word  = f_word(w_sel_entry, w_sel_idx);
        w_sel_last  = w_sel_entry[c_ENT_W-1] ? (w_sel_idx == 4'd0)
                                             : (w_sel_idx == c_KP_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_widx  <= '0;
        end else if (w_advance) begin
            r_data <= w_sel_word;
            r_last <= w_sel_last;
            r_widx <= w_sel_idx;
        end else if (w_load_new) begin
            if (w_avail) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_word;
                r_last  <= w_sel_last;
                r_widx  <= 4'd0;
            end else begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_widx  <= 4'd0;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_brief_desc_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_brief_desc_packer
//  Purpose  : Self-checking bench for brief_desc_packer. A record-level
//             reference model (queue of expected words plus record occupancy)
//             predicts every output word, o_last, o_valid and o_overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_brief_desc_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef BRIEF_PACK_CHECKSUM_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_pixel_valid = 1'b0;
    logic         i_flag = 1'b0;
    logic [9:0]   i_coor_x = '0;
    logic [9:0]   i_coor_y = '0;
    logic [7:0]   i_score = '0;
    logic [255:0] i_descriptor = '0;
    logic         i_start = 1'b0;
    logic         i_end = 1'b0;
    logic [31:0]  o_data;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic         o_last;
    logic         o_overflow;

    always #5 i_clk = ~i_clk;

    brief_desc_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pixel_valid(i_pixel_valid),
        .i_flag       (i_flag),
        .i_coor_x     (i_coor_x),
        .i_coor_y     (i_coor_y),
        .i_score      (i_score),
        .i_descriptor (i_descriptor),
        .i_start      (i_start),
        .i_end        (i_end),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_overflow   (o_overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [32:0] exp_q[$];   // {last, word} in output order
    logic [31:0] got_q[$];   // words accepted by the sink
    int          m_occ;      // records resident in the FIFO
    int          m_kp;
    int          m_drop;
    logic        m_ovf;
    logic        m_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_occ   = 0;
        m_kp    = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance model.
    task automatic cycle(input logic pv, input logic fl, input logic st, input logic en,
                         input logic [9:0] x, input logic [9:0] y, input logic [7:0] sc,
                         input logic [255:0] d, input logic rdy);
        int          free;
        logic        pop_last;
        logic [32:0] w;
        logic [31:0] hdr;
        logic [31:0] cs;
        logic [9:0]  dr;
        logic [15:0] kc;
        @(negedge i_clk);
        i_pixel_valid = pv; i_flag = fl; i_start = st; i_end = en;
        i_coor_x = x; i_coor_y = y; i_score = sc; i_descriptor = d; i_ready = rdy;

        check("o_valid", o_valid, m_valid);
        check("o_overflow", o_overflow, m_ovf);
        pop_last = 1'b0;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", o_valid, 1'b0);
            end else begin
                check("o_data", o_data, exp_q[0][31:0]);
                check("o_last", o_last, exp_q[0][32]);
                if (rdy) begin
                    w = exp_q.pop_front();
                    got_q.push_back(o_data);
                    pop_last = w[32];
                end
            end
        end
        m_valid = (exp_q.size() > 0);

        free = DEPTH - m_occ;
        if (pv && en && free >= 1) begin
            dr = m_drop[9:0];
            kc = m_kp[15:0];
            exp_q.push_back({1'b1, 32'h8000_0000 | (32'(dr) << 20) | 32'(kc)});
            m_occ++;
            free--;
        end
        if (pv && (en || st)) begin
            m_kp   = 0;
            m_drop = 0;
        end
        if (pv && fl) begin
            if (free >= 2) begin
                hdr = (32'd1 << 30) | (32'(y) << 20) | (32'(x) << 10) | (32'(sc) << 2);
                exp_q.push_back({(NW == 1), hdr});
                cs = hdr;
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back({(k == 7 && NW == 9), d[32*k +: 32]});
                    cs = cs ^ d[32*k +: 32];
                end
                if (NW == 10) exp_q.push_back({1'b1, cs});
                m_occ++;
                if (m_kp < 65535) m_kp++;
            end else begin
                if (m_drop < 1023) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (pop_last) m_occ--;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) idle(1'b1);
        check("drain_empty", exp_q.size(), 0);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1; i_pixel_valid = 1'b0; i_flag = 1'b0; i_start = 1'b0;
        i_end = 1'b0; i_ready = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_o_last", o_last, 1'b0);
        check("rst_o_overflow", o_overflow, 1'b0);
    endtask

    function automatic logic [255:0] rand_desc();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        logic [255:0] d;
        logic [31:0]  cs;
        int           nkp;
        int           ncyc;
        model_reset();

        // --- Single keypoint, streaming sink
        do_reset();
        for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
        got_q.delete();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'd5, 10'd7, 8'h3C, d, 1'b1);
        drain();
        check("t1_nwords", got_q.size(), NW);
        if (got_q.size() == NW) begin
            check("t1_header", got_q[0], 32'h4070_14F0);
            check("t1_desc0", got_q[1], 32'hA5A5_0000);
            check("t1_desc7", got_q[8], 32'hA5A5_0007);
`ifdef BRIEF_PACK_CHECKSUM_EN
            cs = '0;
            for (int k = 0; k < 9; k++) cs = cs ^ got_q[k];
            check("t1_checksum", got_q[9], cs);
`endif
        end

        // --- Start, three keypoints, end
        got_q.delete();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'(i), 10'(i + 1), 8'(i), rand_desc(), 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        drain();
        check("t2_nwords", got_q.size(), 3 * NW + 1);
        if (got_q.size() == 3 * NW + 1) check("t2_trailer", got_q[3 * NW], 32'h8000_0003);

        // --- Back-pressure: four keypoints into a four-entry FIFO, then end
        do_reset();
        got_q.delete();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'(i), 10'(i), 8'(i), rand_desc(), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
        idle(1'b0);
        check("t3_overflow", o_overflow, 1'b1);
        drain();
        check("t3_nwords", got_q.size(), 3 * NW + 1);
        // three kept, one dropped
        if (got_q.size() == 3 * NW + 1) check("t3_trailer", got_q[3 * NW], 32'h8010_0003);

        // --- Keypoint and end in the same cycle
        do_reset();
        got_q.delete();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 10'd1, 8'd1, rand_desc(), 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd2, 8'd2, rand_desc(), 1'b1);
        drain();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 10'd9, 10'd3, 8'h11, rand_desc(), 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        drain();
        check("t4_nwords", got_q.size(), 3 * NW + 2);
        if (got_q.size() == 3 * NW + 2) begin
            check("t4_trailer_a", got_q[2 * NW], 32'h8000_0002);
            check("t4_header", got_q[2 * NW + 1], 32'h4030_2444);
            check("t4_trailer_b", got_q[3 * NW + 1], 32'h8000_0001);
        end

        // --- Reset in the middle of a record
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'd4, 10'd4, 8'd4, rand_desc(), 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);

        // --- Randomised traffic with random back-pressure
        nkp  = 0;
        ncyc = 0;
        while (nkp < 200 && ncyc < 20000) begin
            logic pv, fl, st, en;
            pv = ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 9) < 2);
            en = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 39) == 0);
            if (pv && fl) nkp++;
            cycle(pv, fl, st, en, 10'($urandom()), 10'($urandom()), 8'($urandom()),
                  rand_desc(), 1'($urandom_range(0, 1)));
            ncyc++;
        end
        check("rand_kp_issued", nkp, 200);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
